// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared state encoding, constants and source-match helper for the pipeline controller
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_DRAIN,
    ST_TRAP_IRQ,
    ST_TRAP_EXC,
    ST_ERET
  } ctrl_state_t;

  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [31:0] ILLOP    = 32'h8000_0004;
  localparam logic [31:0] XADR     = 32'h8000_0008;

  // A producer in register 0 can never create a dependency.
  function automatic logic src_hit(
    input logic [4:0] rd,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       use_rs,
    input logic       use_rt
  );
    return (rd != REG_ZERO) && ((use_rs && (rs == rd)) || (use_rt && (rt == rd)));
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use and branch/jr operand hazard detection
module hazard_detect
  import cpu_pkg::*;
(
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_use_rs,
  input  logic       i_id_use_rt,
  input  logic       i_id_is_branch,
  input  logic       i_id_is_jr,
  input  logic       i_ex_reg_write,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rd,
  input  logic       i_mem_mem_read,
  input  logic [4:0] i_mem_rd,
  output logic       o_stall
);

  logic w_ex_hit;
  logic w_mem_hit;
  logic w_load_use;
  logic w_ctrl;

  assign w_ex_hit   = src_hit(i_ex_rd, i_id_rs, i_id_rt, i_id_use_rs, i_id_use_rt);
  assign w_mem_hit  = src_hit(i_mem_rd, i_id_rs, i_id_rt, i_id_use_rs, i_id_use_rt);
  assign w_load_use = i_ex_mem_read & w_ex_hit;
  // Branches and jr resolve in ID, so they also wait on ALU results still in EX and loads in MEM.
  assign w_ctrl     = (i_id_is_branch | i_id_is_jr) &
                      ((i_ex_reg_write & w_ex_hit) | (i_mem_mem_read & w_mem_hit));
  assign o_stall    = i_id_valid & (w_load_use | w_ctrl);

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard stall, control transfer and interrupt/exception/eret sequencer
module pipeline_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ID_valid,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_use_rs,
  input  logic             ID_use_rt,
  input  logic             ID_is_branch,
  input  logic             ID_is_jr,
  input  logic             ID_is_j,
  input  logic             ID_is_eret,
  input  logic             ID_undef,
  input  logic             ID_cmp_true,
  input  logic [31:0]      ID_PC_plus4,
  input  logic             EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_rd,
  input  logic             MEM_MemRead,
  input  logic [4:0]       MEM_rd,
  input  logic             irq_req,
  output logic             PC_IF_ID_Write,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             Z,
  output logic             J,
  output logic             JR,
  output logic             eret_sel,
  output logic             interrupt,
  output logic             exception,
  output logic [31:0]      epc,
  output logic             kernel,
  output logic [CNT_W-1:0] stall_cnt
);

  ctrl_state_t      r_state;
  ctrl_state_t      w_next;
  logic [31:0]      r_epc;
  logic             r_kernel;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_stall;
  logic             w_normal;
  logic             w_safe;

  hazard_detect u_hazard_detect (
    .i_id_valid     (ID_valid),
    .i_id_rs        (ID_rs),
    .i_id_rt        (ID_rt),
    .i_id_use_rs    (ID_use_rs),
    .i_id_use_rt    (ID_use_rt),
    .i_id_is_branch (ID_is_branch),
    .i_id_is_jr     (ID_is_jr),
    .i_ex_reg_write (EX_RegWrite),
    .i_ex_mem_read  (EX_MemRead),
    .i_ex_rd        (EX_rd),
    .i_mem_mem_read (MEM_MemRead),
    .i_mem_rd       (MEM_rd),
    .o_stall        (w_stall)
  );

  assign w_normal = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  // An interrupt may only squash a plain instruction that will replay cleanly from its own PC.
  assign w_safe   = ID_valid & ~w_stall & ~(ID_is_branch | ID_is_j | ID_is_jr | ID_is_eret);

  always_comb begin
    w_next         = r_state;
    PC_IF_ID_Write = 1'b1;
    IF_ID_flush    = 1'b0;
    ID_EX_flush    = 1'b0;
    Z              = 1'b0;
    J              = 1'b0;
    JR             = 1'b0;
    eret_sel       = 1'b0;
    interrupt      = 1'b0;
    exception      = 1'b0;

    if (w_normal) begin
      if (w_stall) begin
        PC_IF_ID_Write = 1'b0;
        ID_EX_flush    = 1'b1;
      end else begin
        Z           = ID_is_branch & ID_cmp_true;
        J           = ID_is_j;
        JR          = ID_is_jr;
        IF_ID_flush = (ID_is_branch & ID_cmp_true) | ID_is_j | ID_is_jr;
      end
    end

    case (r_state)
      ST_RUN: begin
        if (ID_undef && ID_valid) begin
          w_next = ST_TRAP_EXC;
        end else if (irq_req && !r_kernel) begin
          w_next = w_safe ? ST_TRAP_IRQ : ST_DRAIN;
        end else if (ID_is_eret && ID_valid && r_kernel) begin
          w_next = ST_ERET;
        end
      end
      ST_DRAIN: begin
        if (!irq_req) begin
          w_next = ST_RUN;
        end else if (w_safe) begin
          w_next = ST_TRAP_IRQ;
        end
      end
      ST_TRAP_IRQ: begin
        interrupt   = 1'b1;
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
        w_next      = ST_RUN;
      end
      ST_TRAP_EXC: begin
        exception   = 1'b1;
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
        w_next      = ST_RUN;
      end
      ST_ERET: begin
        eret_sel    = 1'b1;
        IF_ID_flush = 1'b1;
        w_next      = ST_RUN;
      end
      default: w_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_epc       <= 32'd0;
      r_kernel    <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_normal && w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      case (r_state)
        ST_TRAP_IRQ: begin
          r_epc    <= ID_PC_plus4 - 32'd4;
          r_kernel <= 1'b1;
        end
        ST_TRAP_EXC: begin
          r_epc    <= ID_PC_plus4;
          r_kernel <= 1'b1;
        end
        ST_ERET: r_kernel <= 1'b0;
        default: ;
      endcase
    end
  end

  assign epc       = r_epc;
  assign kernel    = r_kernel;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             ID_valid;
  logic [4:0]       ID_rs;
  logic [4:0]       ID_rt;
  logic             ID_use_rs;
  logic             ID_use_rt;
  logic             ID_is_branch;
  logic             ID_is_jr;
  logic             ID_is_j;
  logic             ID_is_eret;
  logic             ID_undef;
  logic             ID_cmp_true;
  logic [31:0]      ID_PC_plus4;
  logic             EX_RegWrite;
  logic             EX_MemRead;
  logic [4:0]       EX_rd;
  logic             MEM_MemRead;
  logic [4:0]       MEM_rd;
  logic             irq_req;
  logic             PC_IF_ID_Write;
  logic             IF_ID_flush;
  logic             ID_EX_flush;
  logic             Z;
  logic             J;
  logic             JR;
  logic             eret_sel;
  logic             interrupt;
  logic             exception;
  logic [31:0]      epc;
  logic             kernel;
  logic [CNT_W-1:0] stall_cnt;

  int n_checks;
  int n_fail;

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ID_valid       (ID_valid),
    .ID_rs          (ID_rs),
    .ID_rt          (ID_rt),
    .ID_use_rs      (ID_use_rs),
    .ID_use_rt      (ID_use_rt),
    .ID_is_branch   (ID_is_branch),
    .ID_is_jr       (ID_is_jr),
    .ID_is_j        (ID_is_j),
    .ID_is_eret     (ID_is_eret),
    .ID_undef       (ID_undef),
    .ID_cmp_true    (ID_cmp_true),
    .ID_PC_plus4    (ID_PC_plus4),
    .EX_RegWrite    (EX_RegWrite),
    .EX_MemRead     (EX_MemRead),
    .EX_rd          (EX_rd),
    .MEM_MemRead    (MEM_MemRead),
    .MEM_rd         (MEM_rd),
    .irq_req        (irq_req),
    .PC_IF_ID_Write (PC_IF_ID_Write),
    .IF_ID_flush    (IF_ID_flush),
    .ID_EX_flush    (ID_EX_flush),
    .Z              (Z),
    .J              (J),
    .JR             (JR),
    .eret_sel       (eret_sel),
    .interrupt      (interrupt),
    .exception      (exception),
    .epc            (epc),
    .kernel         (kernel),
    .stall_cnt      (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plain add in ID with no dependencies, nothing in EX/MEM.
  task automatic clr();
    ID_valid     = 1'b1;
    ID_rs        = 5'd1;
    ID_rt        = 5'd2;
    ID_use_rs    = 1'b0;
    ID_use_rt    = 1'b0;
    ID_is_branch = 1'b0;
    ID_is_jr     = 1'b0;
    ID_is_j      = 1'b0;
    ID_is_eret   = 1'b0;
    ID_undef     = 1'b0;
    ID_cmp_true  = 1'b0;
    ID_PC_plus4  = 32'h0000_0010;
    EX_RegWrite  = 1'b0;
    EX_MemRead   = 1'b0;
    EX_rd        = 5'd0;
    MEM_MemRead  = 1'b0;
    MEM_rd       = 5'd0;
    irq_req      = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    clr();
    ID_valid = 1'b0;
    tick();
    tick();
    chk("rst_pcw", PC_IF_ID_Write, 1);
    chk("rst_flush", {IF_ID_flush, ID_EX_flush, Z, J, JR, eret_sel, interrupt, exception}, 0);
    chk("rst_epc", epc, 0);
    chk("rst_kernel", kernel, 0);
    chk("rst_cnt", stall_cnt, 0);
    rst_n = 1'b1;

    // load-use on rs=8
    clr();
    ID_rs = 5'd8; ID_use_rs = 1'b1; EX_MemRead = 1'b1; EX_rd = 5'd8;
    #1;
    chk("lu_pcw", PC_IF_ID_Write, 0);
    chk("lu_idex", ID_EX_flush, 1);
    chk("lu_ifid", IF_ID_flush, 0);
    tick();
    chk("lu_cnt", stall_cnt, 1);
    EX_MemRead = 1'b0;
    #1;
    chk("lu_release", {PC_IF_ID_Write, ID_EX_flush}, 2'b10);

    // register 0 never hazards
    clr();
    ID_rs = 5'd0; ID_use_rs = 1'b1; EX_MemRead = 1'b1; EX_rd = 5'd0;
    #1;
    chk("r0_pcw", PC_IF_ID_Write, 1);

    // beq vs ALU result in EX, then taken
    clr();
    ID_is_branch = 1'b1; ID_rs = 5'd9; ID_use_rs = 1'b1; ID_cmp_true = 1'b1;
    EX_RegWrite = 1'b1; EX_rd = 5'd9;
    #1;
    chk("br_stall", {PC_IF_ID_Write, ID_EX_flush, Z}, 3'b010);
    tick();
    chk("br_cnt", stall_cnt, 2);
    EX_RegWrite = 1'b0;
    #1;
    chk("br_taken", {Z, IF_ID_flush, PC_IF_ID_Write}, 3'b111);
    tick();
    clr();
    #1;
    chk("br_after", {Z, IF_ID_flush}, 2'b00);

    // jr vs load in MEM (rt operand)
    clr();
    ID_is_jr = 1'b1; ID_rt = 5'd12; ID_use_rt = 1'b1; MEM_MemRead = 1'b1; MEM_rd = 5'd12;
    #1;
    chk("jr_mem_stall", {PC_IF_ID_Write, JR}, 2'b00);
    tick();
    chk("jr_cnt", stall_cnt, 3);

    // irq while j in ID: drain, then trap on safe add
    clr();
    ID_is_j = 1'b1; irq_req = 1'b1;
    #1;
    chk("drn_j", {J, IF_ID_flush}, 2'b11);
    tick();
    ID_is_j = 1'b0; ID_PC_plus4 = 32'h40;
    #1;
    chk("drn_wait", {interrupt, J}, 2'b00);
    tick();
    ID_is_j = 1'b1;
    #1;
    chk("irq_out", {interrupt, IF_ID_flush, ID_EX_flush, PC_IF_ID_Write, J}, 5'b11110);
    tick();
    ID_is_j = 1'b0;
    #1;
    chk("irq_epc", epc, 32'h3C);
    chk("irq_kernel", kernel, 1);
    chk("irq_done", interrupt, 0);
    tick();
    chk("irq_masked", interrupt, 0);

    // eret with kernel=1
    clr();
    ID_is_eret = 1'b1;
    #1;
    chk("eret_pre", eret_sel, 0);
    tick();
    clr();
    #1;
    chk("eret_out", {eret_sel, IF_ID_flush, ID_EX_flush}, 3'b110);
    tick();
    chk("eret_kernel", kernel, 0);

    // eret with kernel=0 is a nop
    ID_is_eret = 1'b1;
    tick();
    chk("eret_nop", {eret_sel, IF_ID_flush, ID_EX_flush, interrupt, exception}, 0);
    chk("eret_nop_k", kernel, 0);

    // exception beats simultaneous irq
    clr();
    ID_undef = 1'b1; ID_PC_plus4 = 32'h100; irq_req = 1'b1;
    tick();
    #1;
    chk("exc_out", {exception, interrupt, IF_ID_flush, ID_EX_flush}, 4'b1011);
    tick();
    chk("exc_epc", epc, 32'h100);
    chk("exc_kernel", kernel, 1);
    clr();
    irq_req = 1'b1;
    tick();
    tick();
    chk("exc_irq_ign", {interrupt, exception}, 0);

    // exception in kernel overwrites epc
    ID_undef = 1'b1; ID_PC_plus4 = 32'h200;
    tick();
    chk("kexc_out", exception, 1);
    tick();
    chk("kexc_epc", epc, 32'h200);

    // leave kernel, then reset in the middle of TRAP_IRQ
    clr();
    ID_is_eret = 1'b1;
    tick();
    clr();
    tick();
    chk("pre_rst_k", kernel, 0);
    irq_req = 1'b1;
    tick();
    chk("mid_irq", interrupt, 1);
    rst_n = 1'b0;
    #1;
    chk("async_int", interrupt, 0);
    chk("async_epc", epc, 0);
    chk("async_cnt", stall_cnt, 0);
    chk("async_pcw", PC_IF_ID_Write, 1);
    tick();
    rst_n = 1'b1;
    clr();

    // saturation: 2^CNT_W+3 consecutive stalls
    ID_rs = 5'd8; ID_use_rs = 1'b1; EX_MemRead = 1'b1; EX_rd = 5'd8;
    repeat (65534) tick();
    chk("sat_fffe", stall_cnt, 16'hFFFE);
    tick();
    chk("sat_ffff", stall_cnt, 16'hFFFF);
    repeat (4) tick();
    chk("sat_hold", stall_cnt, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central hazard and trap sequencer for the 5-stage CPU; sits beside ID.
- Detects load-use and branch/JR operand hazards, then drives PC_IF_ID_Write and the pipeline flushes.
- Converts taken branch/J/JR decisions into IF PC-select strobes.
- Sequences interrupt and exception entry and ERET exit through an FSM, and owns EPC and a saturating stall counter.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- ID_valid  in  1  IF_ID holds a real instruction (not a bubble)
- ID_rs, ID_rt  in  5 each  source registers of the ID instruction
- ID_use_rs, ID_use_rt  in  1 each  ID instruction reads rs / rt
- ID_is_branch, ID_is_jr, ID_is_j, ID_is_eret  in  1 each  ID instruction class
- ID_undef  in  1  ID instruction is undefined (exception source)
- ID_cmp_true  in  1  branch condition is true in ID
- ID_PC_plus4  in  32  PC+4 of the ID instruction
- EX_RegWrite, EX_MemRead  in  1 each  EX stage controls
- EX_rd  in  5  EX destination register
- MEM_MemRead  in  1  MEM stage is a load
- MEM_rd  in  5  MEM destination register
- irq_req  in  1  level interrupt request (timer/UART)
- PC_IF_ID_Write  out  1  0 = hold PC and IF_ID
- IF_ID_flush  out  1  squash IF_ID next edge
- ID_EX_flush  out  1  insert bubble into ID_EX next edge
- Z, J, JR  out  1 each  IF next-PC select: branch / jump / jr target
- eret_sel  out  1  IF takes epc as next PC
- interrupt, exception  out  1 each  IF status: select interrupt / exception vector
- epc  out  32  saved return address
- kernel  out  1  in handler; interrupts masked
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (async): FSM=RUN; epc=0; kernel=0; stall_cnt=0; PC_IF_ID_Write=1. All other outputs are combinational and evaluate to 0 under the reset state.
- Hazards (combinational, ID_valid=1, register 0 never hazards):
  - Load-use: EX_MemRead and EX_rd matches a used rs/rt.
  - Ctrl: (ID_is_branch or ID_is_jr) and either EX_RegWrite with EX_rd matching a used source, or MEM_MemRead with MEM_rd matching a used source.
  - stall = load-use or ctrl.
  - On stall: PC_IF_ID_Write=0, ID_EX_flush=1, and Z/J/JR are suppressed.
- Control transfer (no stall, FSM=RUN):
  - Z = ID_is_branch & ID_cmp_true; J = ID_is_j; JR = ID_is_jr.
  - Any of these asserts IF_ID_flush=1 for that cycle only. There is no delay slot.
- stall_cnt increments on each stall cycle and saturates at all-ones.
- FSM states:
  - RUN:
    - ID_undef & ID_valid → TRAP_EXC. Exception has priority over interrupt, and is taken even when kernel=1.
    - Else irq_req & ~kernel: → TRAP_IRQ when safe, otherwise → DRAIN.
    - safe = ID_valid & ~stall & ~(ID_is_branch|ID_is_j|ID_is_jr|ID_is_eret).
    - Else ID_is_eret & ID_valid & kernel → ERET.
  - DRAIN:
    - Normal hazard and control handling continues.
    - → TRAP_IRQ on the first safe cycle.
    - If irq_req drops first → RUN (no trap).
  - TRAP_IRQ (1 cycle): interrupt=1, IF_ID_flush=1, ID_EX_flush=1, epc ← ID_PC_plus4−4 (the squashed ID instruction re-executes), kernel ← 1 → RUN.
  - TRAP_EXC (1 cycle): exception=1, both flushes, epc ← ID_PC_plus4 (the faulting instruction is skipped), kernel ← 1 → RUN.
  - ERET (1 cycle): eret_sel=1, IF_ID_flush=1, kernel ← 0 → RUN.
  - ID_is_eret with kernel=0 is ignored (treated as a nop).
- Trap-state outputs override Z/J/JR (forced 0). PC_IF_ID_Write=1 in trap states.
- Exception while kernel=1 overwrites epc. This is decided behaviour; there is no nesting.
- Reset mid-trap returns to RUN with kernel=0 immediately.

Decomposition:
- Shared package cpu_pkg holds:
  - FSM state encoding (RUN, DRAIN, TRAP_IRQ, TRAP_EXC, ERET).
  - Register-0 constant.
  - Vector addresses ILLOP=32'h80000004, XADR=32'h80000008 (used by IF).
- One sub-module, hazard_detect: purely combinational; produces stall from the ID/EX/MEM fields.

Test Plan:
- Load-use: EX lw $8 (EX_MemRead=1, EX_rd=8), ID add reading rs=8 → one cycle of PC_IF_ID_Write=0, ID_EX_flush=1; stall_cnt 0→1.
- beq in ID with rs=9, EX_RegWrite rd=9 → stall for 1 cycle. Next cycle, with ID_cmp_true=1 → Z=1, IF_ID_flush=1 for exactly 1 cycle.
- irq_req=1 while ID holds a j → state DRAIN, J=1 honoured. Next cycle, safe instruction with ID_PC_plus4=0x40 → interrupt=1, epc=0x3C, kernel=1.
- ID_undef with ID_PC_plus4=0x100 plus simultaneous irq_req → exception=1 only, epc=0x100. irq_req is then ignored while kernel=1.
- eret in ID with kernel=1 → eret_sel=1, IF_ID_flush=1, kernel=0. eret with kernel=0 → no outputs asserted.
- Assert rst_n=0 during TRAP_IRQ → outputs return to reset values asynchronously. 2^CNT_W+3 consecutive stalls → stall_cnt holds at all-ones.
